uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 12000000, inter-byte timeout in clk cycles (1 s at 12 MHz).
REQ-002 SHALL have parameter AW, default 9, memory address width (512x8 block RAM).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetq  input  1  reset, asynchronous and active-low.
REQ-005 rx_valid  input  1  UART receiver holds a received byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_rd  output  1  level; byte consumed on any cycle with rx_valid && rx_rd.
REQ-008 tx_busy  input  1  UART transmitter busy.
REQ-009 tx_wr  output  1  one-cycle write strobe to transmitter.
REQ-010 tx_data  output  8  byte to transmit, stable while tx_wr high.
REQ-011 mem_we  output  1  memory write enable, one cycle per byte.
REQ-012 mem_waddr  output  AW  write address.
REQ-013 mem_wdata  output  8  write data.
REQ-014 mem_raddr  output  AW  read address; RAM returns data one cycle later.
REQ-015 mem_rdata  input  8  read data.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 Command frame: cmd, addr_hi (bit0 used as address bit 8, bits 7:1 ignored), addr_lo, count N (0 means 256), then payload.
REQ-018 IDLE: rx_rd=1; byte 0x4C ('L') -> A_HI with op=write; 0x52 ('R') -> A_HI with op=read; any other byte consumed and ignored.
REQ-019 A_HI -> A_LO -> CNT: one byte each, rx_rd=1; CNT -> W_DATA (write) or R_ISSUE (read).
REQ-020 W_DATA: each accepted byte registered; mem_we=1 on the next cycle with current address/data; address then +1, wrapping 0x1FF -> 0x000; 8-bit checksum += byte mod 256.
REQ-021 After byte N is written: transmit checksum, then 0x4B ('K'), then IDLE.
REQ-022 R_ISSUE: drive mem_raddr, rx_rd=0; R_WAIT captures mem_rdata exactly one cycle later; transmit it; address +1 with wrap; repeat N times; then transmit 'K', then IDLE.
REQ-023 Transmit handshake: tx_wr=1 for exactly one cycle, only in a cycle where tx_busy=0; tx_busy is not sampled again for one cycle after tx_wr (TX_END gap).
REQ-024 rx_rd=0 in every transmit and read state; incoming bytes wait in the receiver and are not consumed.
REQ-025 Timeout: in A_HI, A_LO, CNT, W_DATA a counter clears on each accepted byte; on reaching TIMEOUT the block returns to IDLE, transmits nothing, and does no further writes; bytes already written stay written.
REQ-026 A byte accepted on the same cycle the timeout expires counts as accepted; the timeout does not fire.
REQ-027 Commands are not nested: 'L'/'R' bytes inside a frame are treated as data.

Reset
REQ-028 resetq low SHALL asynchronously force: state IDLE, tx_wr=0, mem_we=0, rx_rd=0 while asserted, tx_data=0, addresses=0, checksum=0, counters=0, busy=0.
REQ-029 Reset mid-frame or mid-transmit aborts it; no partial strobe is emitted after resetq deasserts.
REQ-030 After deassertion: IDLE with rx_rd=1 from the first clock.

Structure
REQ-031 Shared package loader_pkg: state enum, CMD_LOAD=0x4C, CMD_READ=0x52, ACK=0x4B.
REQ-032 One sub-module, loader_txq: owns the tx_wr/tx_busy handshake and TX_END gap; request/byte in, done out.
REQ-033 Timeout counter width SHALL be the ceiling of log2(TIMEOUT+1).

Verification
REQ-034 Load: 4C 00 10 03 AA BB CC -> writes 0x010=AA, 0x011=BB, 0x012=CC; transmits 0x31 then 4B.
REQ-035 Wrap: 4C 01 FF 02 11 22 -> writes 0x1FF=11, 0x000=22; transmits 0x33, 4B.
REQ-036 Readback: 52 00 10 03 after REQ-034 -> transmits AA BB CC 4B; rx_rd=0 throughout the read.
REQ-037 Count 0: 4C 00 00 00 then 256 bytes 0x01 -> 256 mem_we pulses; transmits 0x00, 4B.
REQ-038 Timeout: TIMEOUT=100; 4C 00 05 02 EE, then silence for 101 cycles -> only 0x005=EE written; nothing transmitted; busy=0; next 'R' frame is accepted.
REQ-039 Reset: resetq pulsed low during the checksum transmit -> tx_wr stays 0, state IDLE; tx_busy held high -> no tx_wr until it falls.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and protocol constants for the UART memory loader.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_HI,
    S_A_LO,
    S_CNT,
    S_W_DATA,
    S_TX_CSUM,
    S_TX_ACK,
    S_R_ISSUE,
    S_R_WAIT,
    S_R_TX
  } state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_END,
    T_GAP
  } txq_state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] ACK      = 8'h4B;

endpackage

// File: rtl/uart_loader_if.sv
// UART receive/transmit and block-RAM port bundle between the loader and its surroundings.
interface uart_loader_if #(
    parameter int AW = 9
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_rd;
    logic          tx_busy;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;

    modport master (
        input  rx_valid, rx_data, tx_busy, mem_rdata,
        output rx_rd, tx_wr, tx_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, mem_rdata,
        input  rx_rd, tx_wr, tx_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/loader_txq.sv
// Single-byte transmit handshake: waits for tx_busy low, strobes tx_wr once,
// then holds off one gap cycle before the transmitter status is trusted again.
module loader_txq
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       resetq,
    input  logic       req,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       done,
    output logic       tx_wr,
    output logic [7:0] tx_data
);
    txq_state_t st_q, st_d;
    logic       tx_wr_q, tx_wr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       done_q, done_d;

    always_comb begin
        st_d      = st_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        case (st_q)
            T_IDLE: begin
                if (req && !tx_busy) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = byte_in;
                    st_d      = T_END;
                end
            end
            T_END: begin
                done_d = 1'b1;
                st_d   = T_GAP;
            end
            // requester sees done during this cycle and drops or changes req
            T_GAP:   st_d = T_IDLE;
            default: st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            st_q      <= T_IDLE;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    assign done    = done_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;
endmodule

// File: rtl/uart_loader.sv
// UART-driven block-RAM loader: 'L' frames write payload bytes and return a
// checksum plus 'K'; 'R' frames stream memory back followed by 'K'.
module uart_loader
    import loader_pkg::*;
#(
    parameter int TIMEOUT = 12000000,
    parameter int AW      = 9
) (
    input  logic              clk,
    input  logic              resetq,
    uart_loader_if.master     bus,
    output logic              busy
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      rbuf_q, rbuf_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [7:0]      wdata_q, wdata_d;

    logic            rx_rd;
    logic            accept;
    logic            timed;
    logic            tx_req;
    logic [7:0]      tx_byte;
    logic            tx_done;

    assign timed  = state_q inside {S_A_HI, S_A_LO, S_CNT, S_W_DATA};
    // gated by resetq so nothing is consumed while reset is held
    assign rx_rd  = resetq && (timed || state_q == S_IDLE);
    assign accept = bus.rx_valid && rx_rd;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        rbuf_d  = rbuf_q;
        to_d    = '0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        tx_req  = 1'b0;
        tx_byte = ACK;

        if (timed) to_d = accept ? '0 : to_q + TO_W'(1);

        case (state_q)
            S_IDLE: begin
                if (accept && bus.rx_data == CMD_LOAD) begin
                    op_d    = 1'b0;
                    state_d = S_A_HI;
                end else if (accept && bus.rx_data == CMD_READ) begin
                    op_d    = 1'b1;
                    state_d = S_A_HI;
                end
            end
            S_A_HI: if (accept) begin
                addr_d  = AW'({bus.rx_data[0], 8'h00});
                state_d = S_A_LO;
            end
            S_A_LO: if (accept) begin
                addr_d  = addr_q | AW'(bus.rx_data);
                state_d = S_CNT;
            end
            S_CNT: if (accept) begin
                cnt_d   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                csum_d  = 8'h00;
                state_d = op_q ? S_R_ISSUE : S_W_DATA;
            end
            S_W_DATA: if (accept) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = bus.rx_data;
                addr_d  = addr_q + AW'(1);
                csum_d  = csum_q + bus.rx_data;
                cnt_d   = cnt_q - 9'd1;
                if (cnt_q == 9'd1) state_d = S_TX_CSUM;
            end
            S_TX_CSUM: begin
                tx_req  = 1'b1;
                tx_byte = csum_q;
                if (tx_done) state_d = S_TX_ACK;
            end
            S_TX_ACK: begin
                tx_req = 1'b1;
                if (tx_done) state_d = S_IDLE;
            end
            S_R_ISSUE: state_d = S_R_WAIT;
            S_R_WAIT: begin
                rbuf_d  = bus.mem_rdata;
                state_d = S_R_TX;
            end
            S_R_TX: begin
                tx_req  = 1'b1;
                tx_byte = rbuf_q;
                if (tx_done) begin
                    addr_d  = addr_q + AW'(1);
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? S_TX_ACK : S_R_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // an accepted byte always wins over an expiring timeout
        if (timed && !accept && to_q == TO_W'(TIMEOUT)) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= 8'h00;
            rbuf_q  <= 8'h00;
            to_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            rbuf_q  <= rbuf_d;
            to_q    <= to_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    loader_txq u_txq (
        .clk     (clk),
        .resetq  (resetq),
        .req     (tx_req),
        .byte_in (tx_byte),
        .tx_busy (bus.tx_busy),
        .done    (tx_done),
        .tx_wr   (bus.tx_wr),
        .tx_data (bus.tx_data)
    );

    assign bus.rx_rd     = rx_rd;
    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_raddr = addr_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a 512x8 RAM model and a transmitter model.
module tb_uart_loader;
    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic busy;
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rd_watch = 1'b0;
    int   rd_hits = 0;
    logic wr_prev = 1'b0;

    logic [7:0] ram [512];
    logic [8:0] wr_a [$];
    logic [7:0] wr_d [$];
    logic [7:0] tx_log [$];

    uart_loader_if #(.AW(9)) bif ();

    uart_loader #(.TIMEOUT(100), .AW(9)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bif),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    assign bif.tx_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (bif.mem_we) begin
            wr_a.push_back(bif.mem_waddr);
            wr_d.push_back(bif.mem_wdata);
            ram[bif.mem_waddr] <= bif.mem_wdata;
        end
        bif.mem_rdata <= ram[bif.mem_raddr];
        if (bif.tx_wr) begin
            tx_log.push_back(bif.tx_data);
            busy_cnt <= 3;
            checks++;
            if (bif.tx_busy !== 1'b0 || wr_prev !== 1'b0) begin
                errors++;
                $display("FAIL tx_strobe busy=%0b prev_wr=%0b required 0/0", bif.tx_busy, wr_prev);
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        wr_prev <= bif.tx_wr;
        if (rd_watch && bif.rx_rd) rd_hits++;
    end

    // call right after a negedge; returns at the negedge after the byte was consumed
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        while (bif.rx_rd !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bif.rx_rd !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%02h rx_rd=%0b required 1", b, bif.rx_rd);
        end
        @(negedge clk);
        bif.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            if (tx_log.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        tx_log.delete();
    endtask

    task automatic test_reset();
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        resetq = 1'b0;
        #1;
        checks++;
        if ({bif.rx_rd, bif.tx_wr, bif.mem_we, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl rd/wr/we/busy=%04b required 0000",
                     {bif.rx_rd, bif.tx_wr, bif.mem_we, busy});
        end
        checks++;
        if (bif.tx_data !== 8'h00 || bif.mem_waddr !== 9'h000 || bif.mem_raddr !== 9'h000) begin
            errors++;
            $display("FAIL reset_data tx_data=%02h waddr=%03h raddr=%03h required 00/000/000",
                     bif.tx_data, bif.mem_waddr, bif.mem_raddr);
        end
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        #1;
        checks++;
        if (bif.rx_rd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rx_rd=%0b busy=%0b required 1/0", bif.rx_rd, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        clear_logs();
        send_byte(8'h41);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_log.size() != 0) begin
            errors++;
            $display("FAIL ignore busy=%0b tx_count=%0d required 0/0", busy, tx_log.size());
        end
    endtask

    task automatic test_load();
        logic [7:0] frame [7] = '{8'h4C, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        logic [8:0] exp_a [3] = '{9'h010, 9'h011, 9'h012};
        logic [7:0] exp_d [3] = '{8'hAA, 8'hBB, 8'hCC};
        logic [7:0] exp_t [2] = '{8'h31, 8'h4B};
        bit ok;
        clear_logs();
        foreach (frame[i]) send_byte(frame[i]);
        wait_tx(2, ok);
        checks++;
        if (!ok || wr_a.size() != 3 || tx_log.size() != 2) begin
            errors++;
            $display("FAIL load_counts writes=%0d tx=%0d required 3/2", wr_a.size(), tx_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL load_write%0d got %03h=%02h required %03h=%02h",
                             i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (tx_log[i] !== exp_t[i]) begin
                    errors++;
                    $display("FAIL load_tx%0d got %02h required %02h", i, tx_log[i], exp_t[i]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_idle busy=%0b required 0", busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] frame [6] = '{8'h4C, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22};
        bit ok;
        clear_logs();
        foreach (frame[i]) send_byte(frame[i]);
        wait_tx(2, ok);
        checks++;
        if (!ok || wr_a.size() != 2 || tx_log.size() != 2) begin
            errors++;
            $display("FAIL wrap_counts writes=%0d tx=%0d required 2/2", wr_a.size(), tx_log.size());
        end else begin
            checks++;
            if (wr_a[0] !== 9'h1FF || wr_d[0] !== 8'h11 || wr_a[1] !== 9'h000 || wr_d[1] !== 8'h22) begin
                errors++;
                $display("FAIL wrap_writes got %03h=%02h %03h=%02h required 1ff=11 000=22",
                         wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
            end
            checks++;
            if (tx_log[0] !== 8'h33 || tx_log[1] !== 8'h4B) begin
                errors++;
                $display("FAIL wrap_tx got %02h %02h required 33 4b", tx_log[0], tx_log[1]);
            end
        end
    endtask

    task automatic test_readback();
        logic [7:0] frame [4] = '{8'h52, 8'h00, 8'h10, 8'h03};
        logic [7:0] exp_t [4] = '{8'hAA, 8'hBB, 8'hCC, 8'h4B};
        bit ok;
        clear_logs();
        foreach (frame[i]) send_byte(frame[i]);
        // a pending byte must sit untouched for the whole read
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'h00;
        rd_hits  = 0;
        rd_watch = 1'b1;
        for (int k = 0; k < 5000 && tx_log.size() < 4; k++) @(negedge clk);
        rd_watch = 1'b0;
        ok = (tx_log.size() == 4);
        repeat (6) @(negedge clk);
        bif.rx_valid = 1'b0;
        checks++;
        if (rd_hits != 0) begin
            errors++;
            $display("FAIL read_rx_rd high_cycles=%0d required 0", rd_hits);
        end
        checks++;
        if (!ok || tx_log.size() != 4 || wr_a.size() != 0) begin
            errors++;
            $display("FAIL read_counts tx=%0d writes=%0d required 4/0", tx_log.size(), wr_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tx_log[i] !== exp_t[i]) begin
                    errors++;
                    $display("FAIL read_tx%0d got %02h required %02h", i, tx_log[i], exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_count0();
        int bad = 0;
        bit ok;
        clear_logs();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'h01);
        wait_tx(2, ok);
        checks++;
        if (wr_a.size() != 256) begin
            errors++;
            $display("FAIL count0_writes got %0d required 256", wr_a.size());
        end else begin
            for (int i = 0; i < 256; i++)
                if (wr_a[i] !== 9'(i) || wr_d[i] !== 8'h01) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL count0_content bad_entries=%0d required 0", bad);
            end
        end
        checks++;
        if (!ok || tx_log.size() != 2 || tx_log[0] !== 8'h00 || tx_log[1] !== 8'h4B) begin
            errors++;
            $display("FAIL count0_tx count=%0d required 2 bytes 00 4b", tx_log.size());
        end
    endtask

    task automatic test_nested();
        logic [7:0] frame [5] = '{8'h4C, 8'h00, 8'h20, 8'h01, 8'h52};
        bit ok;
        clear_logs();
        foreach (frame[i]) send_byte(frame[i]);
        wait_tx(2, ok);
        checks++;
        if (!ok || wr_a.size() != 1 || wr_a[0] !== 9'h020 || wr_d[0] !== 8'h52 ||
            tx_log.size() != 2 || tx_log[0] !== 8'h52 || tx_log[1] !== 8'h4B) begin
            errors++;
            $display("FAIL nested writes=%0d tx=%0d required 020=52 then tx 52 4b",
                     wr_a.size(), tx_log.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] frame [5] = '{8'h4C, 8'h00, 8'h05, 8'h02, 8'hEE};
        logic [7:0] rframe [4] = '{8'h52, 8'h00, 8'h05, 8'h01};
        bit ok;
        clear_logs();
        foreach (frame[i]) send_byte(frame[i]);
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early busy=%0b required 1", busy);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_log.size() != 0) begin
            errors++;
            $display("FAIL timeout_abort busy=%0b tx=%0d required 0/0", busy, tx_log.size());
        end
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 9'h005 || wr_d[0] !== 8'hEE) begin
            errors++;
            $display("FAIL timeout_writes count=%0d required 1 (005=ee)", wr_a.size());
        end
        foreach (rframe[i]) send_byte(rframe[i]);
        wait_tx(2, ok);
        checks++;
        if (!ok || tx_log.size() != 2 || tx_log[0] !== 8'hEE || tx_log[1] !== 8'h4B) begin
            errors++;
            $display("FAIL timeout_next_read tx=%0d required ee 4b", tx_log.size());
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] frame [5] = '{8'h4C, 8'h00, 8'h30, 8'h01, 8'h77};
        clear_logs();
        force_busy = 1'b1;
        foreach (frame[i]) send_byte(frame[i]);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_log.size() != 0) begin
            errors++;
            $display("FAIL hold_before_reset busy=%0b tx=%0d required 1/0", busy, tx_log.size());
        end
        resetq = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bif.rx_rd !== 1'b0 || bif.tx_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%0b rx_rd=%0b tx_wr=%0b required 0/0/0",
                     busy, bif.rx_rd, bif.tx_wr);
        end
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        force_busy = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_log.size() != 0 || busy !== 1'b0 || bif.rx_rd !== 1'b1) begin
            errors++;
            $display("FAIL reset_after tx=%0d busy=%0b rx_rd=%0b required 0/0/1",
                     tx_log.size(), busy, bif.rx_rd);
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] frame [5] = '{8'h4C, 8'h00, 8'h31, 8'h01, 8'h05};
        bit ok;
        clear_logs();
        force_busy = 1'b1;
        foreach (frame[i]) send_byte(frame[i]);
        repeat (20) @(negedge clk);
        checks++;
        if (tx_log.size() != 0) begin
            errors++;
            $display("FAIL busy_hold tx=%0d required 0", tx_log.size());
        end
        force_busy = 1'b0;
        wait_tx(2, ok);
        checks++;
        if (!ok || tx_log.size() != 2 || tx_log[0] !== 8'h05 || tx_log[1] !== 8'h4B) begin
            errors++;
            $display("FAIL busy_release tx=%0d required 05 4b", tx_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_load();
        test_wrap();
        test_readback();
        test_count0();
        test_nested();
        test_timeout();
        test_reset_mid_tx();
        test_busy_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
